pixel_array_ctrl: RTL and testbench

- Upstream sequencer and downstream readout for the 4-pixel array. It generates ERASE, EXPOSE, CONVERT, READ and the pixel reset.
- During CONVERT it drives the 8-bit ramp count onto the shared DATA bus. Each comparator latches that count, so the latched value is the pixel code.
- It then reads each pixel back one at a time and emits the codes on a valid/ready stream.
- It sits between the system frame trigger and the pixel array. An external tristate, enabled by DATA_OE, joins DATA_OUT/DATA_IN to the array's DATA inout.

---
 rtl/pixel_ctrl_pkg.sv | 24 ++
 rtl/pixel_ctrl_timer.sv | 26 ++
 rtl/pixel_array_ctrl.sv | 131 +++++++++++++
 tb/tb_pixel_array_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and constants for the pixel array sequencer.
// State encoding, bus widths and default phase lengths.
package pixel_ctrl_pkg;

  localparam int DATA_W            = 8;
  localparam int RAMP_STEPS        = 256;
  localparam int IDX_W             = 2;
  localparam int ERASE_CYCLES_DEF  = 5;
  localparam int EXPOSE_CYCLES_DEF = 255;
  localparam int NUM_PIXELS_DEF    = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_GAP,
    ST_RD_SETTLE,
    ST_RD_CAPTURE,
    ST_OUT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pixel_ctrl_timer.sv
// Loadable 8-bit phase down-counter; done flags the final cycle of a phase.
// Latency: load value visible the cycle after load; count 1 marks the last cycle.
// Backpressure: none, free-running decrement when not loading.
module pixel_ctrl_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else begin
      count <= count - 8'd1;
    end
  end

  // A load of 0 wraps through 255..1, giving a 256-cycle phase.
  assign done = (count == 8'd1);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp convert, then per-pixel readout.
// Latency: ERASE+EXPOSE+256+1+3*NUM_PIXELS+1 cycles START->FRAME_DONE with PIX_READY high.
// Backpressure: PIX_READY low holds OUT with PIX_DATA/PIX_INDEX stable, indefinitely.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES  = ERASE_CYCLES_DEF,
  parameter int unsigned EXPOSE_CYCLES = EXPOSE_CYCLES_DEF,
  parameter int unsigned NUM_PIXELS    = NUM_PIXELS_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  PIX_RESET,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  CONVERT,
  output logic [NUM_PIXELS-1:0] READ,
  output logic [DATA_W-1:0]     DATA_OUT,
  output logic                  DATA_OE,
  input  logic [DATA_W-1:0]     DATA_IN,
  output logic [DATA_W-1:0]     PIX_DATA,
  output logic [IDX_W-1:0]      PIX_INDEX,
  output logic                  PIX_VALID,
  input  logic                  PIX_READY,
  output logic                  FRAME_DONE
);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              tmr_load, tmr_done;
  logic [DATA_W-1:0] tmr_val, tmr_cnt;
  logic              xfer, last_pix;

  assign xfer     = (state == ST_OUT) && PIX_READY;
  assign last_pix = (idx == IDX_W'(NUM_PIXELS - 1));

  pixel_ctrl_timer u_timer (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .done     (tmr_done)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (START) state_nxt = ST_ERASE;
      ST_ERASE:      if (tmr_done) state_nxt = ST_EXPOSE;
      ST_EXPOSE:     if (tmr_done) state_nxt = ST_CONVERT;
      ST_CONVERT:    if (tmr_done) state_nxt = ST_GAP;
      ST_GAP:        state_nxt = ST_RD_SETTLE;
      ST_RD_SETTLE:  state_nxt = ST_RD_CAPTURE;
      ST_RD_CAPTURE: state_nxt = ST_OUT;
      ST_OUT:        if (xfer) state_nxt = last_pix ? ST_DONE : ST_RD_SETTLE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Timer is reloaded on every state change with the length of the phase being entered.
  always_comb begin
    tmr_load = (state_nxt != state);
    case (state_nxt)
      ST_ERASE:   tmr_val = DATA_W'(ERASE_CYCLES);
      ST_EXPOSE:  tmr_val = DATA_W'(EXPOSE_CYCLES);
      ST_CONVERT: tmr_val = DATA_W'(RAMP_STEPS);
      default:    tmr_val = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx       <= '0;
      PIX_DATA  <= '0;
      PIX_INDEX <= '0;
    end else begin
      if (state == ST_GAP) begin
        idx <= '0;
      end else if (xfer && !last_pix) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_RD_CAPTURE) begin
        PIX_DATA  <= DATA_IN;
        PIX_INDEX <= idx;
      end
    end
  end

  always_comb begin
    BUSY       = (state != ST_IDLE);
    PIX_RESET  = 1'b0;
    ERASE      = 1'b0;
    EXPOSE     = 1'b0;
    CONVERT    = 1'b0;
    DATA_OE    = 1'b0;
    DATA_OUT   = '0;
    READ       = '0;
    PIX_VALID  = 1'b0;
    FRAME_DONE = 1'b0;
    case (state)
      ST_ERASE: begin
        ERASE     = 1'b1;
        PIX_RESET = 1'b1;
      end
      ST_EXPOSE: EXPOSE = 1'b1;
      ST_CONVERT: begin
        CONVERT  = 1'b1;
        DATA_OE  = 1'b1;
        // Timer runs 0,255,...,1 in this phase, so its negation is the 0..255 ramp.
        DATA_OUT = 8'd0 - tmr_cnt;
      end
      ST_RD_SETTLE, ST_RD_CAPTURE: READ = NUM_PIXELS'(1) << idx;
      ST_OUT:  PIX_VALID  = 1'b1;
      ST_DONE: FRAME_DONE = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: default instance plus a 1/1-cycle erase/expose instance.
module tb_pixel_array_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start_x;
  logic       ready;
  logic       sel;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 CLK = ~CLK;

  logic       a_busy, a_pix_reset, a_erase, a_expose, a_convert, a_data_oe, a_valid, a_fdone;
  logic [3:0] a_read;
  logic [7:0] a_data_out, a_din, a_pix_data;
  logic [1:0] a_pix_index;
  logic       b_busy, b_pix_reset, b_erase, b_expose, b_convert, b_data_oe, b_valid, b_fdone;
  logic [3:0] b_read;
  logic [7:0] b_data_out, b_din, b_pix_data;
  logic [1:0] b_pix_index;
  logic [3:0] a_read_q, b_read_q;

  pixel_array_ctrl u_dut_a (
    .CLK(CLK), .RESET(rst_n), .START(start_x && !sel), .BUSY(a_busy),
    .PIX_RESET(a_pix_reset), .ERASE(a_erase), .EXPOSE(a_expose), .CONVERT(a_convert),
    .READ(a_read), .DATA_OUT(a_data_out), .DATA_OE(a_data_oe), .DATA_IN(a_din),
    .PIX_DATA(a_pix_data), .PIX_INDEX(a_pix_index), .PIX_VALID(a_valid),
    .PIX_READY(ready), .FRAME_DONE(a_fdone)
  );

  pixel_array_ctrl #(.ERASE_CYCLES(1), .EXPOSE_CYCLES(1)) u_dut_b (
    .CLK(CLK), .RESET(rst_n), .START(start_x && sel), .BUSY(b_busy),
    .PIX_RESET(b_pix_reset), .ERASE(b_erase), .EXPOSE(b_expose), .CONVERT(b_convert),
    .READ(b_read), .DATA_OUT(b_data_out), .DATA_OE(b_data_oe), .DATA_IN(b_din),
    .PIX_DATA(b_pix_data), .PIX_INDEX(b_pix_index), .PIX_VALID(b_valid),
    .PIX_READY(ready), .FRAME_DONE(b_fdone)
  );

  // Pixel i answers 8'h10+i, but only once its READ has been held for a settle cycle.
  always @(posedge CLK) begin
    a_read_q <= a_read;
    b_read_q <= b_read;
  end

  always_comb begin
    a_din = 8'hEE;
    b_din = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      if (a_read[i] && a_read_q[i]) a_din = 8'(8'h10 + i);
      if (b_read[i] && b_read_q[i]) b_din = 8'(8'h10 + i);
    end
  end

  logic       o_busy, o_erase, o_expose, o_convert, o_data_oe, o_valid, o_fdone;
  logic [3:0] o_read;
  logic [7:0] o_data_out, o_pix_data;
  logic [1:0] o_pix_index;
  logic [29:0] a_vec;

  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_erase     = sel ? b_erase     : a_erase;
  assign o_expose    = sel ? b_expose    : a_expose;
  assign o_convert   = sel ? b_convert   : a_convert;
  assign o_data_oe   = sel ? b_data_oe   : a_data_oe;
  assign o_valid     = sel ? b_valid     : a_valid;
  assign o_fdone     = sel ? b_fdone     : a_fdone;
  assign o_read      = sel ? b_read      : a_read;
  assign o_data_out  = sel ? b_data_out  : a_data_out;
  assign o_pix_data  = sel ? b_pix_data  : a_pix_data;
  assign o_pix_index = sel ? b_pix_index : a_pix_index;
  assign a_vec = {a_busy, a_pix_reset, a_erase, a_expose, a_convert, a_read, a_data_out,
                  a_data_oe, a_pix_data, a_pix_index, a_valid, a_fdone};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    check("inv_a_bus",    32'(a_data_oe && (a_read != 4'd0)), 32'd0);
    check("inv_a_excl",   32'($onehot0({a_erase, a_expose, a_convert, |a_read})), 32'd1);
    check("inv_a_onehot", 32'($onehot0(a_read)), 32'd1);
    check("inv_a_pixrst", 32'(a_pix_reset == a_erase), 32'd1);
    check("inv_b_bus",    32'(b_data_oe && (b_read != 4'd0)), 32'd0);
    check("inv_b_excl",   32'($onehot0({b_erase, b_expose, b_convert, |b_read})), 32'd1);
    check("inv_b_onehot", 32'($onehot0(b_read)), 32'd1);
    check("inv_b_pixrst", 32'(b_pix_reset == b_erase), 32'd1);
  end

  task automatic run_frame(input int stall, input int exp_len, input bit poke, input int idle_after,
                           input int exp_er, input int exp_ex);
    int t = 1, done_t = -1, hold = 0, got = 0, idle_busy = 0;
    int n_er = 0, n_ex = 0, n_cv = 0, n_gap = 0, ramp_err = 0, stab_err = 0, rd_err = 0;
    logic [7:0] cap_d = '0;
    logic [1:0] cap_i = '0;
    logic [7:0] rx_d [4];
    logic [1:0] rx_i [4];
    for (int i = 0; i < 4; i++) begin
      rx_d[i] = '0;
      rx_i[i] = '0;
    end
    start_x = 1'b1;
    ready   = (stall == 0);
    @(negedge CLK);
    while (done_t < 0 && t < 5000) begin
      start_x = 1'b0;
      if (o_erase)  n_er++;
      if (o_expose) n_ex++;
      if (o_convert) begin
        if (o_data_out != 8'(n_cv) || !o_data_oe) ramp_err++;
        n_cv++;
      end
      if (o_busy && !o_erase && !o_expose && !o_convert && o_read == 4'd0 && !o_valid && !o_fdone)
        n_gap++;
      if (o_fdone) done_t = t;
      if (o_valid) begin
        if (o_read != 4'd0) rd_err++;
        if (hold == 0) begin
          cap_d = o_pix_data;
          cap_i = o_pix_index;
        end else if (o_pix_data != cap_d || o_pix_index != cap_i) begin
          stab_err++;
        end
        if (hold < stall) begin
          ready = 1'b0;
          hold++;
        end else begin
          ready = 1'b1;
          if (got < 4) begin
            rx_d[got] = o_pix_data;
            rx_i[got] = o_pix_index;
          end
          got++;
          hold = 0;
        end
      end else begin
        ready = (stall == 0);
      end
      if (poke && (t == 100 || (o_valid && got == 2))) start_x = 1'b1;
      @(negedge CLK);
      t++;
    end
    start_x = 1'b0;
    ready   = 1'b1;
    check("frame_timeout", 32'(done_t >= 0), 32'd1);
    check("erase_len",  32'(n_er), 32'(exp_er));
    check("expose_len", 32'(n_ex), 32'(exp_ex));
    check("convert_len", 32'(n_cv), 32'd256);
    check("gap_len",    32'(n_gap), 32'd1);
    check("ramp_errs",  32'(ramp_err), 32'd0);
    check("read_in_out", 32'(rd_err), 32'd0);
    check("stable_errs", 32'(stab_err), 32'd0);
    check("xfer_count", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rx_index", 32'(rx_i[i]), 32'(i));
      check("rx_data",  32'(rx_d[i]), 32'(8'h10 + i));
    end
    check("frame_len",  32'(done_t), 32'(exp_len));
    check("done_pulse", 32'({o_fdone, o_busy}), 32'd0);
    for (int i = 0; i < idle_after; i++) begin
      @(negedge CLK);
      if (o_busy || o_fdone) idle_busy++;
    end
    check("idle_after", 32'(idle_busy), 32'd0);
  endtask

  initial begin
    int n = 0, seen = 0;
    sel     = 1'b0;
    start_x = 1'b0;
    ready   = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_outs_a", 32'(a_vec), 32'd0);
    check("rst_busy_b", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_outs_a", 32'(a_vec), 32'd0);
    check("idle_busy_b", 32'(b_busy), 32'd0);

    run_frame(0, 530, 1'b0, 2, 5, 255);
    run_frame(20, 610, 1'b0, 2, 5, 255);
    run_frame(0, 530, 1'b1, 20, 5, 255);

    start_x = 1'b1;
    @(negedge CLK);
    start_x = 1'b0;
    while (!(a_convert && a_data_out == 8'd100) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("midrst_reach", 32'(a_convert && a_data_out == 8'd100), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'(a_vec), 32'd0);
    check("midrst_oe_cv", 32'({a_data_oe, a_convert}), 32'd0);
    repeat (3) @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (a_busy || a_fdone) seen++;
    end
    check("midrst_quiet", 32'(seen), 32'd0);
    run_frame(0, 530, 1'b0, 2, 5, 255);

    sel = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(0, 272, 1'b0, 0, 1, 1);
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
